// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage.
//   NOP_INSTR      : canonical bubble (addi x0, x0, 0)
//   fetch_entry_t  : {pc, instr} pair held in the fetch buffers
//   word_align()   : clears the byte-offset bits of an address
package fetch_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch_entry_t.
//   push/push_data : enqueue (ignored when full unless popping the same cycle)
//   pop            : dequeue head (ignored when empty)
//   clear          : flush all entries; wins over push and pop
//   head_c         : current head entry (combinational read of storage)
//   count/empty    : registered occupancy
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               head_c,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_next_c;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Effective push/pop and next occupancy.
    always_comb begin
        do_pop_c     = pop && !clear && !empty;
        do_push_c    = push && !clear && ((32'(count) < DEPTH) || do_pop_c);
        count_next_c = count;
        if (clear) begin
            count_next_c = '0;
        end else if (do_push_c && !do_pop_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    assign head_c = mem[rd_ptr];

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            count <= count_next_c;
            empty <= (count_next_c == '0);
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push_c) wr_ptr <= ptr_inc(wr_ptr);
                if (do_pop_c)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//   clk, rst                 : clock, asynchronous active-high reset
//   pc_src_e, pc_target_e    : redirect from execute
//   stall_d, flush_d         : hazard-unit hold / bubble for IF/ID
//   imem_req/addr/gnt        : fetch request handshake (req & gnt)
//   imem_rvalid/rdata        : in-order fetch responses
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID contents presented to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    input  logic        stall_d,
    input  logic        flush_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    localparam int unsigned BCNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCNT_W = $clog2(MAX_OUTST + 1);

    logic [31:0]       pc_f;
    logic [OCNT_W-1:0] outst;
    logic [OCNT_W-1:0] drop;
    logic [OCNT_W-1:0] outst_next_c;
    logic              hs_c;
    logic              rsp_c;
    logic              keep_c;
    logic              pop_c;
    logic              issue_ok_c;

    fetch_entry_t      pcq_push_c;
    fetch_entry_t      pcq_head_c;
    logic [OCNT_W-1:0] pcq_count;
    logic              pcq_empty;

    fetch_entry_t      buf_push_c;
    fetch_entry_t      buf_head_c;
    logic [BCNT_W-1:0] buf_count;
    logic              buf_empty;

    // Issue only when every outstanding word is guaranteed a buffer slot.
    // The in-flight queue tracks the same quantity as outst; both gate issue.
    assign issue_ok_c = (32'(outst) + 32'(buf_count) < BUF_DEPTH)
                     && (32'(outst) < MAX_OUTST)
                     && (32'(pcq_count) < MAX_OUTST);
    assign imem_req   = !rst && !pc_src_e && issue_ok_c;
    assign imem_addr  = pc_f;

    // Handshake, response accounting and buffer push/pop decisions.
    always_comb begin
        hs_c         = imem_req && imem_gnt;
        rsp_c        = imem_rvalid && !pcq_empty;
        keep_c       = rsp_c && (drop == '0) && !pc_src_e;
        pop_c        = !flush_d && !stall_d && !buf_empty;
        outst_next_c = outst;
        if (hs_c && !rsp_c) begin
            outst_next_c = outst + OCNT_W'(1);
        end else if (rsp_c && !hs_c) begin
            outst_next_c = outst - OCNT_W'(1);
        end

        pcq_push_c       = '0;
        pcq_push_c.pc    = pc_f;
        pcq_push_c.instr = NOP_INSTR;

        buf_push_c       = pcq_head_c;
        buf_push_c.instr = imem_rdata;
    end

    // PC of every granted request, consumed in order as responses return.
    fetch_buffer #(.DEPTH(MAX_OUTST)) u_pcq (
        .clk       (clk),
        .rst       (rst),
        .push      (hs_c),
        .push_data (pcq_push_c),
        .pop       (rsp_c),
        .clear     (1'b0),
        .head_c    (pcq_head_c),
        .count     (pcq_count),
        .empty     (pcq_empty)
    );

    // Returned words waiting for decode; a redirect discards them.
    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (keep_c),
        .push_data (buf_push_c),
        .pop       (pop_c),
        .clear     (pc_src_e),
        .head_c    (buf_head_c),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    // Fetch PC, outstanding count and stale-response drop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f  <= RESET_PC;
            outst <= '0;
            drop  <= '0;
        end else begin
            outst <= outst_next_c;
            if (pc_src_e) begin
                pc_f <= word_align(pc_target_e);
                // Everything still in flight after this cycle belongs to the old path.
                drop <= outst_next_c;
            end else begin
                if (hs_c) pc_f <= pc_f + 32'd4;
                if (rsp_c && (drop != '0)) drop <= drop - OCNT_W'(1);
            end
        end
    end

    // IF/ID register: flush > stall > pop > bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (stall_d) begin
            instr_d    <= instr_d;
            pc_d       <= pc_d;
            pc_plus4_d <= pc_plus4_d;
            valid_d    <= valid_d;
        end else if (!buf_empty) begin
            instr_d    <= buf_head_c.instr;
            pc_d       <= buf_head_c.pc;
            pc_plus4_d <= buf_head_c.pc + 32'd4;
            valid_d    <= 1'b1;
        end else begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: the bench plays the instruction memory and
// predicts the decode-side instruction stream (consecutive PCs, restarting at each
// redirect target) and the fetch address sequence.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned MAX_OUTST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        stall_d;
    logic        flush_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          n_valid = 0;
    logic [31:0] prev_instr, prev_pc, prev_pc4;
    logic        prev_valid;
    logic        hs_seen, req_seen;
    logic [31:0] hs_addr_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_81b3;
            32'h0000_000C: return 32'h4020_8233;
            default:       return (a * 32'h9E37_79B9) ^ 32'h0000_0033;
        endcase
    endfunction

    // One clock cycle: memory model, fetch-address model and decode-stream model.
    task automatic tick();
        logic        st, fl, rd, rs;
        logic [31:0] tgt;
        int          due;
        @(negedge clk);
        st = stall_d; fl = flush_d; rd = pc_src_e; tgt = pc_target_e; rs = rst;
        req_seen     = imem_req;
        hs_seen      = imem_req && imem_gnt;
        hs_addr_seen = imem_addr;
        if (rs || rd) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL req_blocked: imem_req=%b required 0 (rst=%b pc_src_e=%b)", imem_req, rs, rd);
            end
        end
        if (!rs && pend_addr.size() >= MAX_OUTST) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL req_outst_limit: imem_req=%b with %0d in flight, required 0", imem_req, pend_addr.size());
            end
        end
        if (hs_seen && !rs) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_fetch);
            end
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(due);
            last_due  = due;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) exp_fetch = {tgt[31:2], 2'b00};

        @(posedge clk);
        #1;
        cyc++;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end

        checks++;
        if (rs) begin
            if (valid_d !== 1'b0 || instr_d !== NOP_INSTR || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b instr=%h pc=%h pc4=%h required 0/%h/0/0",
                         valid_d, instr_d, pc_d, pc_plus4_d, NOP_INSTR);
            end
        end else if (fl) begin
            if (valid_d !== 1'b0 || instr_d !== NOP_INSTR || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
                errors++;
                $display("FAIL flush_bubble: valid=%b instr=%h pc=%h pc4=%h required 0/%h/0/0",
                         valid_d, instr_d, pc_d, pc_plus4_d, NOP_INSTR);
            end
        end else if (st) begin
            if (valid_d !== prev_valid || instr_d !== prev_instr || pc_d !== prev_pc || pc_plus4_d !== prev_pc4) begin
                errors++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h required %b/%h/%h",
                         valid_d, instr_d, pc_d, prev_valid, prev_instr, prev_pc);
            end
        end else if (valid_d === 1'b1) begin
            if (pc_d !== exp_pc || instr_d !== mem_word(exp_pc) || pc_plus4_d !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stream: pc=%h instr=%h pc4=%h required %h/%h/%h",
                         pc_d, instr_d, pc_plus4_d, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
            n_valid++;
        end else begin
            if (valid_d !== 1'b0 || instr_d !== NOP_INSTR) begin
                errors++;
                $display("FAIL bubble: valid=%b instr=%h required 0/%h", valid_d, instr_d, NOP_INSTR);
            end
        end
        if (rd) exp_pc = {tgt[31:2], 2'b00};
        prev_valid = valid_d; prev_instr = instr_d; prev_pc = pc_d; prev_pc4 = pc_plus4_d;
    endtask

    // Hold reset for n cycles (memory keeps answering), then release cleanly.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        pend_addr.delete();
        pend_due.delete();
        last_due    = cyc;
        exp_fetch   = RESET_PC;
        exp_pc      = RESET_PC;
        imem_rvalid = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_src_e = 1'b0; pc_target_e = '0; stall_d = 1'b0; flush_d = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        exp_fetch = RESET_PC; exp_pc = RESET_PC;
        repeat (3) tick();
        checks++;
        if (valid_d !== 1'b0 || instr_d !== NOP_INSTR || pc_d !== 32'h0 || pc_plus4_d !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL test_reset: valid=%b instr=%h pc=%h pc4=%h req=%b required 0/%h/0/0/0",
                     valid_d, instr_d, pc_d, pc_plus4_d, imem_req, NOP_INSTR);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        imem_gnt = 1'b1; lat = 1;
        apply_reset(1);
        tick();
        checks++;
        if (hs_seen !== 1'b1 || hs_addr_seen !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: hs=%b addr=%h required 1/%h", hs_seen, hs_addr_seen, RESET_PC);
        end
        tick();
        checks++;
        if (valid_d !== 1'b0) begin
            errors++;
            $display("FAIL b2b_latency: valid_d=%b one cycle after grant, required 0", valid_d);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_d !== 1'b1 || pc_d !== 32'(i * 4) || instr_d !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         i, valid_d, pc_d, instr_d, 32'(i * 4), mem_word(32'(i * 4)));
            end
        end
        nv = n_valid;
        repeat (10) tick();
        checks++;
        if (n_valid - nv !== 10) begin
            errors++;
            $display("FAIL b2b_throughput: %0d instrs in 10 cycles, required 10", n_valid - nv);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        int nv;
        held_pc = pc_d;
        stall_d = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_seen !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_drop: imem_req=%b on third stall cycle, required 0", req_seen);
        end
        checks++;
        if (pc_d !== held_pc || valid_d !== 1'b1) begin
            errors++;
            $display("FAIL stall_pc: pc_d=%h valid=%b required %h/1", pc_d, valid_d, held_pc);
        end
        stall_d = 1'b0;
        nv = n_valid;
        repeat (12) tick();
        checks++;
        if (n_valid - nv < 10) begin
            errors++;
            $display("FAIL stall_resume: %0d instrs after stall, required >= 10", n_valid - nv);
        end
    endtask

    task automatic test_redirect();
        logic found;
        lat = 3;
        for (int i = 0; i < 12 && pend_addr.size() != 2; i++) tick();
        checks++;
        if (pend_addr.size() != 2) begin
            errors++;
            $display("FAIL redirect_setup: %0d requests in flight, required 2", pend_addr.size());
        end
        pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'h0000_0100;
        tick();
        pc_src_e = 1'b0; flush_d = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_d === 1'b1 && !found) begin
                found = 1'b1;
                checks++;
                if (pc_d !== 32'h0000_0100 || instr_d !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL redirect_target: pc=%h instr=%h required %h/%h",
                             pc_d, instr_d, 32'h100, mem_word(32'h100));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redirect_timeout: valid=%b no instruction after redirect, required 1", valid_d);
        end
    endtask

    task automatic test_gnt_gap();
        int nv;
        lat = 1;
        repeat (10) tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 3) begin
                checks++;
                if (valid_d !== 1'b0 || instr_d !== NOP_INSTR) begin
                    errors++;
                    $display("FAIL gap_bubble: valid=%b instr=%h required 0/%h", valid_d, instr_d, NOP_INSTR);
                end
            end
        end
        imem_gnt = 1'b1; lat = 3;
        nv = n_valid;
        repeat (25) tick();
        checks++;
        if (n_valid - nv < 5) begin
            errors++;
            $display("FAIL gap_resume: %0d instrs after gap, required >= 5", n_valid - nv);
        end
    endtask

    task automatic test_wrap();
        logic        last_was_top, saw_wrap_fetch, saw_top_d, first;
        lat = 1;
        pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'hFFFF_FFF3;
        tick();
        pc_src_e = 1'b0; flush_d = 1'b0;
        last_was_top = 1'b0; saw_wrap_fetch = 1'b0; saw_top_d = 1'b0; first = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (hs_seen) begin
                if (last_was_top) begin
                    saw_wrap_fetch = 1'b1;
                    checks++;
                    if (hs_addr_seen !== 32'h0) begin
                        errors++;
                        $display("FAIL wrap_fetch: imem_addr=%h after FFFFFFFC, required 00000000", hs_addr_seen);
                    end
                end
                last_was_top = (hs_addr_seen == 32'hFFFF_FFFC);
            end
            if (valid_d === 1'b1 && first) begin
                first = 1'b0;
                checks++;
                if (pc_d !== 32'hFFFF_FFF0) begin
                    errors++;
                    $display("FAIL misaligned_target: pc_d=%h required FFFFFFF0", pc_d);
                end
            end
            if (valid_d === 1'b1 && pc_d === 32'hFFFF_FFFC) begin
                saw_top_d = 1'b1;
                checks++;
                if (pc_plus4_d !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_pc_plus4: pc_plus4_d=%h required 00000000", pc_plus4_d);
                end
            end
        end
        checks++;
        if (!saw_wrap_fetch || !saw_top_d) begin
            errors++;
            $display("FAIL wrap_timeout: wrap_fetch=%b top_decoded=%b required 1/1", saw_wrap_fetch, saw_top_d);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        lat = 3;
        for (int i = 0; i < 12 && pend_addr.size() != 2; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (valid_d !== 1'b0 || instr_d !== NOP_INSTR || pc_d !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b instr=%h pc=%h req=%b required 0/%h/0/0",
                     valid_d, instr_d, pc_d, imem_req, NOP_INSTR);
        end
        lat = 1;
        apply_reset(5);
        tick();
        checks++;
        if (hs_seen !== 1'b1 || hs_addr_seen !== RESET_PC) begin
            errors++;
            $display("FAIL reset_refetch: hs=%b addr=%h required 1/%h", hs_seen, hs_addr_seen, RESET_PC);
        end
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid_d === 1'b1 && !found) begin
                found = 1'b1;
                checks++;
                if (pc_d !== RESET_PC) begin
                    errors++;
                    $display("FAIL reset_first_instr: pc_d=%h required %h", pc_d, RESET_PC);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_timeout: valid=%b no instruction after reset, required 1", valid_d);
        end
    endtask

    task automatic test_random();
        int nv;
        nv = n_valid;
        for (int i = 0; i < 500; i++) begin
            imem_gnt = ($urandom_range(0, 3) != 0);
            lat      = $urandom_range(1, 3);
            stall_d  = ($urandom_range(0, 4) == 0);
            pc_src_e = ($urandom_range(0, 24) == 0);
            flush_d  = pc_src_e || ($urandom_range(0, 29) == 0);
            pc_target_e = $urandom();
            tick();
        end
        pc_src_e = 1'b0; flush_d = 1'b0; stall_d = 1'b0; imem_gnt = 1'b1;
        repeat (10) tick();
        checks++;
        if (n_valid - nv < 60) begin
            errors++;
            $display("FAIL random_progress: %0d instrs in random run, required >= 60", n_valid - nv);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_gnt_gap();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
